e191_driver: RTL and testbench
==============================

# e191_driver

Stimulus driver for the e191 Mealy FSM. It generates the FSM's x1..x16 inputs to steer it into a requested state. It keeps a shadow tour position and checks every y1..y11 response against the expected output. It holds the FSM in a self-looping "park" state between requests. It sits on the input side of e191, shares its clock and reset, and reads e191's outputs back.

## Interface
- No parameters; the tour is fixed by the e191 transition table.
- clk  in  1  clock; driver logic is posedge, with one negedge y-capture register.
- rst  in  1  reset, asynchronous, active-high; must be the same net as e191's rst.
- req_valid  in  1  target request.
- req_ready  out  1  request accepted when req_valid && req_ready on a posedge.
- req_state  in  4  target state code, 1..11.
- x_o  out  16  FSM inputs; bit i drives x(i+1).
- y_i  in  11  FSM outputs; bit i is y(i+1).
- parked  out  1  FSM is held in park_state.
- park_state  out  4  current park state code; 0 when not parked.
- done  out  1  one-cycle pulse when a requested target is reached.
- bad_req  out  1  one-cycle pulse when a target is not parkable; the request is dropped.
- err  out  1  sticky y mismatch flag; cleared only by rst.

## Operation
- **Parkable states and hold vectors.** Only s3, s5, s9, s10 can be parked. All x bits not listed are 0.
  - s3: x7=1, x9=1, x8=0.
  - s5: x12=1, x15=0.
  - s9: x4=0.
  - s10: x15=0.
  - Expected y while holding is 0.
- **Tour.** Positions 0..12 wrap after 12. Each entry is state, set x bits (others 0), next state, and the expected single-hot y set.
  - p0: s1, x9 -> s4, y5.
  - p1: s4, x1 -> s6, y1.
  - p2: s6, none -> s8, y2.
  - p3: s8, x11 -> s5, y1.
  - p4: s5, none -> s3, y4.
  - p5: s3, x7 x9 x8 -> s7, y3.
  - p6: s7, x11 x5 -> s5, y1.
  - p7: s5, none -> s3, y4.
  - p8: s3, x6 x4 x13 -> s10, y1+y11.
  - p9: s10, x15 -> s11, y6.
  - p10: s11, none -> s2, y10.
  - p11: s2, none -> s9, y8.
  - p12: s9, x4 -> s1, y9.
- **Control states.** BOOT, WALK, PARK, ERR.
  - BOOT (after rst): walk from p0 to the first park in s5 (p4). This takes 4 steps, with no done pulse.
  - PARK: drive the hold vector, assert parked, and hold req_ready=1.
  - Accepted request for a target that is not parkable: pulse bad_req next cycle and stay in PARK.
  - Accepted request whose target equals park_state: pulse done next cycle, take 0 steps, stay in PARK.
  - Any other accepted request: enter WALK. Step the tour from the current position until the first position whose state equals the target, then PARK there. s3 and s5 each occur twice; the first occurrence forward, with wrap, is used.
  - While in WALK or BOOT, req_ready=0 and parked=0.
  - ERR: entered when captured y differs from expected in any state, including hold. x_o=0, req_ready=0, parked=0, err=1 until rst.

## Timing
- **Per-step pipeline.** One step per clk cycle.
  - Posedge k: the step-k vector is registered on x_o.
  - Negedge k: e191 takes its transition, and the driver captures y_i in the same negedge.
  - Posedge k+1: the captured y is compared with the expected y for step k, and x_o for step k+1 (or the hold vector) is driven in the same edge.
- **Completion.** done pulses at the posedge that checks the final step and drives the hold vector. From s5@p4 to s10 is 5 steps, and done is high in the 6th cycle after acceptance.
- **Reset values.** x_o=0, req_ready=0, parked=0, park_state=0, done=0, bad_req=0, err=0. Position=0, control state BOOT.
  - The first posedge after rst deasserts drives the p0 vector. No compare happens on that edge.
- **Reset mid-walk.** rst aborts immediately to the reset values; e191 returns to s1 on the shared rst.
- A mismatch on the final step gives err, not done.

## Structure
- **e191_pkg:** state codes s1..s11, the parkable set, hold vectors, tour depth 13.
- **e191_tour_rom:** combinational sub-module. Input is the position; outputs are state, x vector, expected y, and next state.
- **e191_driver:** control FSM, position counter, y capture and compare, request handshake.

## Test plan
- **Boot:** release rst; x_o follows p0..p3 (0x0100, 0x0001, 0x0000, 0x0400). y_i sequence is y5, y1, y2, y1. Then parked=1, park_state=5, x_o=0x0800.
- **Walk to s10:** from the s5 park, request 10. Five steps, done in the 6th cycle, park_state=10, x_o=0x0000.
- **Wrap-around:** from s10, request 5. The walk is p9..p12 then p0..p3, 8 steps. Parks at p4, done pulses.
- **Non-parkable target:** request 2. Expect a bad_req pulse, no x change, park_state unchanged. A request equal to park_state gives a done pulse with 0 steps.
- **Fault injection:** force y_i=0 during step p5. err=1 the next cycle, x_o=0, req_ready=0, held until rst.
- **Reset mid-walk:** assert rst during the p6 step. All outputs go to reset values, then boot re-parks at s5.

Source files
------------

// File: rtl/e191_pkg.sv
// Shared constants and helpers for the e191 stimulus driver: state codes,
// tour geometry, the parkable set and the hold vectors that keep e191 in place.
package e191_pkg;

  localparam int TOUR_DEPTH = 13;
  localparam int POS_W      = 4;
  localparam int X_W        = 16;
  localparam int Y_W        = 11;
  localparam int ST_W       = 4;

  typedef logic [ST_W-1:0] state_code_t;

  localparam state_code_t ST_NONE = 4'd0;
  localparam state_code_t ST_S1   = 4'd1;
  localparam state_code_t ST_S2   = 4'd2;
  localparam state_code_t ST_S3   = 4'd3;
  localparam state_code_t ST_S4   = 4'd4;
  localparam state_code_t ST_S5   = 4'd5;
  localparam state_code_t ST_S6   = 4'd6;
  localparam state_code_t ST_S7   = 4'd7;
  localparam state_code_t ST_S8   = 4'd8;
  localparam state_code_t ST_S9   = 4'd9;
  localparam state_code_t ST_S10  = 4'd10;
  localparam state_code_t ST_S11  = 4'd11;

  // Park target used on the way out of reset.
  localparam state_code_t BOOT_PARK = ST_S5;

  typedef enum logic [1:0] {
    CTL_BOOT,
    CTL_WALK,
    CTL_PARK,
    CTL_ERR
  } ctl_state_e;

  // One-hot vector with x(n) set; x(n) lives on bit n-1.
  function automatic logic [X_W-1:0] xb(input int n);
    logic [X_W-1:0] v;
    v        = '0;
    v[n-1]   = 1'b1;
    return v;
  endfunction

  // One-hot vector with y(n) set; y(n) lives on bit n-1.
  function automatic logic [Y_W-1:0] yb(input int n);
    logic [Y_W-1:0] v;
    v        = '0;
    v[n-1]   = 1'b1;
    return v;
  endfunction

  // Only these states have an input vector that self-loops with y=0.
  function automatic logic is_parkable(input state_code_t s);
    return (s == ST_S3) || (s == ST_S5) || (s == ST_S9) || (s == ST_S10);
  endfunction

  // Input vector that keeps e191 sitting in a parkable state.
  function automatic logic [X_W-1:0] hold_vector(input state_code_t s);
    logic [X_W-1:0] v;
    v = '0;
    case (s)
      ST_S3:   v = xb(7) | xb(9);
      ST_S5:   v = xb(12);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Tour position increment with wrap after the last entry.
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p);
    return (p == POS_W'(TOUR_DEPTH - 1)) ? '0 : p + POS_W'(1);
  endfunction

endpackage

// File: rtl/e191_tour_rom.sv
// Fixed tour through e191's transition table. For each position it returns the
// state e191 is in, the x vector to apply, the Mealy y it should answer with,
// and the state it moves to.
module e191_tour_rom
  import e191_pkg::*;
(
  input  logic [POS_W-1:0] pos_i,
  output state_code_t      state_o,
  output logic [X_W-1:0]   x_o,
  output logic [Y_W-1:0]   y_o,
  output state_code_t      next_o
);

  // Position decode; out-of-range codes read as an empty entry.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_o = ST_NONE;
    x_o     = '0;
    y_o     = '0;
    next_o  = ST_NONE;
    case (pos_i)
      4'd0:  begin state_o = ST_S1;  x_o = xb(9);                 y_o = yb(5);         next_o = ST_S4;  end
      4'd1:  begin state_o = ST_S4;  x_o = xb(1);                 y_o = yb(1);         next_o = ST_S6;  end
      4'd2:  begin state_o = ST_S6;  x_o = '0;                    y_o = yb(2);         next_o = ST_S8;  end
      4'd3:  begin state_o = ST_S8;  x_o = xb(11);                y_o = yb(1);         next_o = ST_S5;  end
      4'd4:  begin state_o = ST_S5;  x_o = '0;                    y_o = yb(4);         next_o = ST_S3;  end
      4'd5:  begin state_o = ST_S3;  x_o = xb(7) | xb(9) | xb(8); y_o = yb(3);         next_o = ST_S7;  end
      4'd6:  begin state_o = ST_S7;  x_o = xb(11) | xb(5);        y_o = yb(1);         next_o = ST_S5;  end
      4'd7:  begin state_o = ST_S5;  x_o = '0;                    y_o = yb(4);         next_o = ST_S3;  end
      4'd8:  begin state_o = ST_S3;  x_o = xb(6) | xb(4) | xb(13); y_o = yb(1) | yb(11); next_o = ST_S10; end
      4'd9:  begin state_o = ST_S10; x_o = xb(15);                y_o = yb(6);         next_o = ST_S11; end
      4'd10: begin state_o = ST_S11; x_o = '0;                    y_o = yb(10);        next_o = ST_S2;  end
      4'd11: begin state_o = ST_S2;  x_o = '0;                    y_o = yb(8);         next_o = ST_S9;  end
      4'd12: begin state_o = ST_S9;  x_o = xb(4);                 y_o = yb(9);         next_o = ST_S1;  end
      default: begin end
    endcase
  end

endmodule

// File: rtl/e191_driver.sv
// Stimulus driver for the e191 Mealy FSM. Walks e191 along a fixed tour to a
// requested parkable state, holds it there, and checks every y response
// against the expected value; any disagreement latches a sticky error.
module e191_driver
  import e191_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ST_W-1:0]   req_state,
  output logic [X_W-1:0]    x_o,
  input  logic [Y_W-1:0]    y_i,
  output logic              parked,
  output logic [ST_W-1:0]   park_state,
  output logic              done,
  output logic              bad_req,
  output logic              err
);

  ctl_state_e        ctl_q, ctl_d;
  logic [POS_W-1:0]  pos_q, pos_d;        // next tour step to apply (or the parked position)
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    exp_y_q, exp_y_d;    // y expected for the vector currently on x_o
  logic              chk_q, chk_d;        // a valid y capture is pending comparison
  state_code_t       shadow_q, shadow_d;  // state e191 reaches after the driven step
  state_code_t       target_q, target_d;
  logic              done_q, done_d;
  logic              bad_req_q, bad_req_d;
  logic [Y_W-1:0]    y_cap_q;

  state_code_t       rom_state;
  logic [X_W-1:0]    rom_x;
  logic [Y_W-1:0]    rom_y;
  state_code_t       rom_next;

  state_code_t       walk_target;
  logic              y_mismatch;
  logic              enter_err;

  e191_tour_rom u_rom (
    .pos_i   (pos_q),
    .state_o (rom_state),
    .x_o     (rom_x),
    .y_o     (rom_y),
    .next_o  (rom_next)
  );

  // Capture e191's Mealy response on the same falling edge that it transitions,
  // so the sample reflects the vector applied during the preceding high phase.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) y_cap_q <= '0;
    else     y_cap_q <= y_i;
  end

  // State, position and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q     <= CTL_BOOT;
      pos_q     <= '0;
      x_q       <= '0;
      exp_y_q   <= '0;
      chk_q     <= 1'b0;
      shadow_q  <= ST_S1;
      target_q  <= BOOT_PARK;
      done_q    <= 1'b0;
      bad_req_q <= 1'b0;
    end else begin
      ctl_q     <= ctl_d;
      pos_q     <= pos_d;
      x_q       <= x_d;
      exp_y_q   <= exp_y_d;
      chk_q     <= chk_d;
      shadow_q  <= shadow_d;
      target_q  <= target_d;
      done_q    <= done_d;
      bad_req_q <= bad_req_d;
    end
  end

  assign walk_target = (ctl_q == CTL_BOOT) ? BOOT_PARK : target_q;
  assign y_mismatch  = chk_q && (y_cap_q != exp_y_q);

  // Next-state: check the last step, then either apply the next tour vector,
  // park with the hold vector, or service a request while parked.
  always_comb begin
    ctl_d     = ctl_q;
    pos_d     = pos_q;
    x_d       = x_q;
    exp_y_d   = exp_y_q;
    chk_d     = chk_q;
    shadow_d  = shadow_q;
    target_d  = target_q;
    done_d    = 1'b0;
    bad_req_d = 1'b0;
    enter_err = 1'b0;

    unique case (ctl_q)
      CTL_BOOT, CTL_WALK: begin
        if (y_mismatch) begin
          enter_err = 1'b1;
        end else if (chk_q && (shadow_q == walk_target)) begin
          ctl_d   = CTL_PARK;
          x_d     = hold_vector(walk_target);
          exp_y_d = '0;
          done_d  = (ctl_q == CTL_WALK);
        end else begin
          x_d      = rom_x;
          exp_y_d  = rom_y;
          shadow_d = rom_next;
          pos_d    = next_pos(pos_q);
          chk_d    = 1'b1;
        end
      end

      CTL_PARK: begin
        if (y_mismatch) begin
          enter_err = 1'b1;
        end else if (req_valid) begin
          if (!is_parkable(req_state)) begin
            bad_req_d = 1'b1;
          end else if (req_state == rom_state) begin
            done_d = 1'b1;
          end else begin
            // The first step of the walk leaves on the accepting edge.
            ctl_d    = CTL_WALK;
            target_d = req_state;
            x_d      = rom_x;
            exp_y_d  = rom_y;
            shadow_d = rom_next;
            pos_d    = next_pos(pos_q);
          end
        end
      end

      CTL_ERR: begin
      end

      default: begin
        enter_err = 1'b1;
      end
    endcase

    if (enter_err) begin
      ctl_d     = CTL_ERR;
      x_d       = '0;
      exp_y_d   = '0;
      chk_d     = 1'b0;
      done_d    = 1'b0;
      bad_req_d = 1'b0;
    end
  end

  assign x_o        = x_q;
  assign req_ready  = (ctl_q == CTL_PARK);
  assign parked     = (ctl_q == CTL_PARK);
  assign park_state = (ctl_q == CTL_PARK) ? rom_state : ST_NONE;
  assign done       = done_q;
  assign bad_req    = bad_req_q;
  assign err        = (ctl_q == CTL_ERR);

endmodule

// File: tb/tb_e191_driver.sv
// Bench for e191_driver: a behavioural e191 answers the driver's x vectors,
// and a scoreboard of expected x/y per cycle is filled when each request is
// issued and drained as the driver steps.
module tb_e191_driver;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_state;
  logic [15:0] x_o;
  logic [10:0] y_i;
  logic        parked;
  logic [3:0]  park_state;
  logic        done;
  logic        bad_req;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  e191_driver dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_state  (req_state),
    .x_o        (x_o),
    .y_i        (y_i),
    .parked     (parked),
    .park_state (park_state),
    .done       (done),
    .bad_req    (bad_req),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tour as written in the e191 transition table.
  localparam logic [3:0]  T_ST [13] = '{4'd1, 4'd4, 4'd6, 4'd8, 4'd5, 4'd3, 4'd7,
                                        4'd5, 4'd3, 4'd10, 4'd11, 4'd2, 4'd9};
  localparam logic [15:0] T_X  [13] = '{16'h0100, 16'h0001, 16'h0000, 16'h0400,
                                        16'h0000, 16'h01C0, 16'h0410, 16'h0000,
                                        16'h1028, 16'h4000, 16'h0000, 16'h0000,
                                        16'h0008};
  localparam logic [10:0] T_Y  [13] = '{11'h010, 11'h001, 11'h002, 11'h001,
                                        11'h008, 11'h004, 11'h001, 11'h008,
                                        11'h401, 11'h020, 11'h200, 11'h080,
                                        11'h100};
  localparam logic [3:0]  T_NX [13] = '{4'd4, 4'd6, 4'd8, 4'd5, 4'd3, 4'd7, 4'd5,
                                        4'd3, 4'd10, 4'd11, 4'd2, 4'd9, 4'd1};

  // Behavioural e191: known (state, x) pairs move and answer; anything else
  // (including the hold vectors) self-loops with y=0.
  logic [3:0]  m_state;
  logic [3:0]  m_next;
  logic [10:0] m_y;
  logic        y_kill;

  always_comb begin
    m_next = m_state;
    m_y    = '0;
    for (int i = 0; i < 13; i++) begin
      if (T_ST[i] == m_state && T_X[i] == x_o) begin
        m_next = T_NX[i];
        m_y    = T_Y[i];
      end
    end
  end

  always @(negedge clk or posedge rst) begin
    if (rst) m_state <= 4'd1;
    else     m_state <= m_next;
  end

  assign y_i = y_kill ? 11'h000 : m_y;

  function automatic logic [15:0] hold_x(input logic [3:0] s);
    case (s)
      4'd3:    return 16'h0140;
      4'd5:    return 16'h0800;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [10:0] y;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   tb_pos;

  // Queue the expected per-cycle vectors for a walk from tb_pos to target.
  task automatic push_walk(input logic [3:0] target);
    exp_t e;
    do begin
      e.x = T_X[tb_pos]; e.y = T_Y[tb_pos]; e.last = 1'b0;
      sb.push_back(e);
      tb_pos = (tb_pos + 1) % 13;
    end while (T_ST[tb_pos] != target);
    e.x = hold_x(target); e.y = 11'h000; e.last = 1'b1;
    sb.push_back(e);
  endtask

  // Pop one expectation per rising edge and compare what the DUT drives.
  task automatic drain(input logic is_walk, input logic [3:0] target);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("x_o",       32'(x_o),       32'(e.x));
      check("y_i",       32'(y_i),       32'(e.y));
      check("done",      32'(done),      32'(is_walk && e.last));
      check("parked",    32'(parked),    32'(e.last));
      check("req_ready", 32'(req_ready), 32'(e.last));
    end
    check("park_state", 32'(park_state), 32'(target));
    check("err",        32'(err),        32'(0));
  endtask

  task automatic check_reset_values();
    check("rst_x_o",        32'(x_o),        32'(0));
    check("rst_req_ready",  32'(req_ready),  32'(0));
    check("rst_parked",     32'(parked),     32'(0));
    check("rst_park_state", 32'(park_state), 32'(0));
    check("rst_done",       32'(done),       32'(0));
    check("rst_bad_req",    32'(bad_req),    32'(0));
    check("rst_err",        32'(err),        32'(0));
  endtask

  task automatic boot();
    @(negedge clk);
    rst    = 1'b0;
    tb_pos = 0;
    push_walk(4'd5);
    drain(1'b0, 4'd5);
  endtask

  // Must be called just after a rising edge; the next edge accepts.
  task automatic walk_to(input logic [3:0] target);
    req_state = target;
    req_valid = 1'b1;
    push_walk(target);
    drain(1'b1, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_state = 4'd0;
    y_kill    = 1'b0;
    tb_pos    = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();

    boot();

    // Request equal to the current park: done next cycle, no movement.
    req_state = 4'd5; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    check("same_done",   32'(done),       32'(1));
    check("same_x",      32'(x_o),        32'(16'h0800));
    check("same_park",   32'(park_state), 32'(5));
    @(posedge clk); #1;
    check("same_done_clr", 32'(done), 32'(0));

    // Non-parkable target: bad_req pulse, nothing else changes.
    req_state = 4'd2; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    check("bad_pulse",  32'(bad_req),    32'(1));
    check("bad_x",      32'(x_o),        32'(16'h0800));
    check("bad_park",   32'(park_state), 32'(5));
    check("bad_done",   32'(done),       32'(0));
    @(posedge clk); #1;
    check("bad_clr",    32'(bad_req),    32'(0));
    check("bad_parked", 32'(parked),     32'(1));

    walk_to(4'd10);   // p4..p8, five steps
    walk_to(4'd5);    // p9..p12, p0..p3 with wrap
    walk_to(4'd9);    // p4..p11
    walk_to(4'd3);    // p12, p0..p4

    // Corrupt y during the p5 step out of s3.
    req_state = 4'd10; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    y_kill = 1'b1;
    check("flt_step_x", 32'(x_o), 32'(16'h01C0));
    @(negedge clk); #1;
    y_kill = 1'b0;
    @(posedge clk); #1;
    check("flt_err",    32'(err),        32'(1));
    check("flt_x",      32'(x_o),        32'(0));
    check("flt_ready",  32'(req_ready),  32'(0));
    check("flt_parked", 32'(parked),     32'(0));
    check("flt_done",   32'(done),       32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("flt_err_hold", 32'(err), 32'(1));
    check("flt_x_hold",   32'(x_o), 32'(0));

    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values();
    boot();

    // Reset in the middle of a walk, during the p6 step.
    req_state = 4'd10; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_p6_x", 32'(x_o), 32'(16'h0410));
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    boot();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
